// File: rtl/acc_add.sv
// ---------------------------------------------------------------------------
// acc_add -- per-lane accumulation stage fed by the MUL block.
//
// Each accepted beat carries GROUP_SIZE signed products. They are added into
// a signed accumulator. After num_reads_per_iter beats the iteration sum is
// presented on data_out. This repeats for num_iters iterations, and then done
// pulses.
//
// Optional build macro:
//   ACC_ADD_SATURATE_EN  when defined, every accumulate step clamps to the
//                        signed ACC_WIDTH range instead of wrapping.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 asynchronous active-low reset
//   configure           one-cycle pulse: latch counts and (re)start a run
//   num_iters           iterations per run
//   num_reads_per_iter  beats per iteration
//   data_in             GROUP_SIZE products, product k in slice k
//   valid_in            data_in valid
//   avail_out           a beat is accepted this cycle if valid_in is high
//   data_out            signed iteration sum, held until the next result
//   valid_out           one-cycle result strobe
//   avail_in            downstream can take a result
//   done                one-cycle pulse after the final result of a run
// ---------------------------------------------------------------------------
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no run active, no beats accepted
// ACCUM  | accepting beats, or holding a result until avail_in is high
// FINISH | final result is on valid_out now; done pulses in the next cycle
// ---------------------------------------------------------------------------
module acc_add #(
  parameter int GROUP_SIZE             = 2,
  parameter int DATA_WIDTH             = 8,
  parameter int ACC_WIDTH              = 32,
  parameter int LOG_MAX_ITERS          = 4,
  parameter int LOG_MAX_READS_PER_ITER = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 configure,
  input  logic [LOG_MAX_ITERS-1:0]             num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0]    num_reads_per_iter,
  input  logic [2*GROUP_SIZE*DATA_WIDTH-1:0]   data_in,
  input  logic                                 valid_in,
  output logic                                 avail_out,
  output logic [ACC_WIDTH-1:0]                 data_out,
  output logic                                 valid_out,
  input  logic                                 avail_in,
  output logic                                 done
);

  localparam int PROD_W = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t                              state;
  logic signed [ACC_WIDTH-1:0]         acc;
  logic signed [ACC_WIDTH-1:0]         acc_next;
  logic signed [ACC_WIDTH-1:0]         prod_ext [GROUP_SIZE];
  logic                                out_pending;
  logic [LOG_MAX_READS_PER_ITER-1:0]   num_reads_q;
  logic [LOG_MAX_READS_PER_ITER-1:0]   reads_left;
  logic [LOG_MAX_ITERS-1:0]            iters_left;
  logic                                cfg_ok;
  logic                                beat;
  logic                                last_beat;

  // Sign-extend each product to the accumulator width.
  for (genvar g = 0; g < GROUP_SIZE; g++) begin : g_prod
    assign prod_ext[g] = ACC_WIDTH'($signed(data_in[g*PROD_W +: PROD_W]));
  end

`ifdef ACC_ADD_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // Overflow only happens when both operands share a sign and the result
  // does not; clamp toward the operands' sign in that case.
  function automatic logic signed [ACC_WIDTH-1:0] acc_step(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [ACC_WIDTH-1:0] b
  );
    logic signed [ACC_WIDTH-1:0] s;
    s = a + b;
    if ((a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (s[ACC_WIDTH-1] != a[ACC_WIDTH-1])) begin
      s = a[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
    end
    return s;
  endfunction
`else
  function automatic logic signed [ACC_WIDTH-1:0] acc_step(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [ACC_WIDTH-1:0] b
  );
    return a + b;
  endfunction
`endif

  // Products are folded in one at a time so that the saturating build clamps
  // at every step, not only on the beat total.
  always_comb begin
    acc_next = acc;
    for (int k = 0; k < GROUP_SIZE; k++) begin
      acc_next = acc_step(acc_next, prod_ext[k]);
    end
  end

  assign cfg_ok    = (num_iters != '0) && (num_reads_per_iter != '0);
  assign beat      = valid_in && avail_out;
  assign last_beat = (reads_left == LOG_MAX_READS_PER_ITER'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      acc         <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      avail_out   <= 1'b0;
      done        <= 1'b0;
      out_pending <= 1'b0;
      num_reads_q <= '0;
      reads_left  <= '0;
      iters_left  <= '0;
    end else begin
      valid_out <= 1'b0;
      done      <= (state == FINISH);

      if (configure) begin
        // A configure in any state abandons whatever is in flight,
        // including a result still waiting for avail_in.
        acc         <= '0;
        out_pending <= 1'b0;
        if (cfg_ok) begin
          num_reads_q <= num_reads_per_iter;
          reads_left  <= num_reads_per_iter;
          iters_left  <= num_iters;
          avail_out   <= 1'b1;
          state       <= ACCUM;
        end else begin
          reads_left <= '0;
          iters_left <= '0;
          avail_out  <= 1'b0;
          done       <= 1'b1;
          state      <= IDLE;
        end
      end else begin
        case (state)
          IDLE: begin
            avail_out <= 1'b0;
          end

          FINISH: begin
            avail_out <= 1'b0;
            state     <= IDLE;
          end

          ACCUM: begin
            if (out_pending) begin
              if (avail_in) begin
                valid_out   <= 1'b1;
                out_pending <= 1'b0;
                if (iters_left == '0) begin
                  avail_out <= 1'b0;
                  state     <= FINISH;
                end else begin
                  avail_out <= 1'b1;
                end
              end
            end else if (beat) begin
              if (last_beat) begin
                data_out   <= acc_next;
                acc        <= '0;
                reads_left <= num_reads_q;
                iters_left <= iters_left - LOG_MAX_ITERS'(1);
                if (avail_in) begin
                  valid_out <= 1'b1;
                  if (iters_left == LOG_MAX_ITERS'(1)) begin
                    avail_out <= 1'b0;
                    state     <= FINISH;
                  end
                end else begin
                  // Result waits; stop taking beats so data_out stays put.
                  out_pending <= 1'b1;
                  avail_out   <= 1'b0;
                end
              end else begin
                acc        <= acc_next;
                reads_left <= reads_left - LOG_MAX_READS_PER_ITER'(1);
              end
            end
          end

          default: begin
            avail_out <= 1'b0;
            state     <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acc_add.sv
// ---------------------------------------------------------------------------
// tb_acc_add -- bench for acc_add. A behavioural model predicts the
// outputs cycle by cycle from the run rules, and a compare process checks them
// on every falling edge. Directed tests add literal checks on the collected
// results. A second instance with ACC_WIDTH=16 exercises overflow behaviour.
// ---------------------------------------------------------------------------
module tb_acc_add;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        configure = 1'b0;
  logic [3:0]  num_iters = '0;
  logic [7:0]  num_reads_per_iter = '0;
  logic [31:0] data_in = '0;
  logic        valid_in = 1'b0;
  logic        avail_in = 1'b1;
  logic        avail_out;
  logic [31:0] data_out;
  logic        valid_out;
  logic        done;
  logic        d16_avail_out;
  logic [15:0] d16_data_out;
  logic        d16_valid_out;
  logic        d16_done;

  always #5 clk = ~clk;

  acc_add u_dut (
    .clk(clk), .rst(rst), .configure(configure), .num_iters(num_iters),
    .num_reads_per_iter(num_reads_per_iter), .data_in(data_in),
    .valid_in(valid_in), .avail_out(avail_out), .data_out(data_out),
    .valid_out(valid_out), .avail_in(avail_in), .done(done)
  );

  acc_add #(.ACC_WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .configure(configure), .num_iters(num_iters),
    .num_reads_per_iter(num_reads_per_iter), .data_in(data_in),
    .valid_in(valid_in), .avail_out(d16_avail_out), .data_out(d16_data_out),
    .valid_out(d16_valid_out), .avail_in(avail_in), .done(d16_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam longint LMAX = 64'sd2147483647;
  localparam longint LMIN = -64'sd2147483648;

  function automatic longint addp(input longint a, input longint p);
    longint s;
    s = a + p;
`ifdef ACC_ADD_SATURATE_EN
    if (s > LMAX) s = LMAX;
    if (s < LMIN) s = LMIN;
`endif
    return s;
  endfunction

  bit          m_run = 0, m_pend = 0, m_fin = 0;
  int          m_ni = 0, m_nr = 0, m_reads = 0, m_iters = 0;
  longint      m_acc = 0;
  bit          e_valid = 0, e_avail = 0, e_done = 0;
  logic [31:0] e_data = '0;

  always @(posedge clk or negedge rst) begin
    bit     nv, nd;
    longint tmp;
    if (!rst) begin
      m_run = 0; m_pend = 0; m_fin = 0;
      m_reads = 0; m_iters = 0; m_acc = 0;
      e_valid = 0; e_avail = 0; e_done = 0; e_data = '0;
    end else begin
      nv = 0;
      nd = m_fin;
      m_fin = 0;
      tmp = addp(addp(m_acc, longint'($signed(data_in[15:0]))),
                 longint'($signed(data_in[31:16])));
      if (configure) begin
        m_pend = 0;
        if (num_iters != 0 && num_reads_per_iter != 0) begin
          m_run = 1; m_ni = int'(num_iters); m_nr = int'(num_reads_per_iter);
          m_reads = 0; m_iters = 0; m_acc = 0; e_avail = 1;
        end else begin
          m_run = 0; e_avail = 0; nd = 1;
        end
      end else if (m_run) begin
        if (m_pend) begin
          if (avail_in) begin
            nv = 1; m_pend = 0; e_avail = 1;
            if (m_iters == m_ni) begin m_run = 0; e_avail = 0; m_fin = 1; end
          end
        end else if (valid_in && e_avail) begin
          m_reads++;
          if (m_reads == m_nr) begin
            e_data = 32'(tmp); m_acc = 0; m_reads = 0; m_iters++;
            if (avail_in) begin
              nv = 1;
              if (m_iters == m_ni) begin m_run = 0; e_avail = 0; m_fin = 1; end
            end else begin
              m_pend = 1; e_avail = 0;
            end
          end else begin
            m_acc = tmp;
          end
        end
      end
      e_valid = nv;
      e_done  = nd;
    end
  end

  // ---------------- compare and result capture ----------------
  bit          chk_en = 0;
  int          cyc = 0, last_v = 0, last_d = 0, done_cnt = 0, v16_cnt = 0;
  logic [31:0] res_q[$];

  always @(negedge clk) begin
    cyc++;
    if (rst && chk_en) begin
      chk("valid_out", 64'(valid_out), 64'(e_valid));
      chk("avail_out", 64'(avail_out), 64'(e_avail));
      chk("done",      64'(done),      64'(e_done));
      if (e_valid || m_pend) chk("data_out", 64'(data_out), 64'(e_data));
    end
    if (rst) begin
      if (valid_out) begin res_q.push_back(data_out); last_v = cyc; end
      if (done) begin done_cnt++; last_d = cyc; end
      if (d16_valid_out) v16_cnt++;
    end
  end

  function automatic logic [63:0] qget(input int i);
    if (i < res_q.size()) return 64'(res_q[i]);
    return '1;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cfg(input int ni, input int nr);
    configure = 1'b1;
    num_iters = ni[3:0];
    num_reads_per_iter = nr[7:0];
    @(negedge clk);
    configure = 1'b0;
  endtask

  task automatic beat(input int p1, input int p0);
    bit ok, av;
    ok = 0;
    data_in  = {p1[15:0], p0[15:0]};
    valid_in = 1'b1;
    for (int i = 0; i < 200; i++) begin
      av = avail_out;
      @(negedge clk);
      if (av) begin ok = 1; break; end
    end
    valid_in = 1'b0;
    if (!ok) chk("beat_accept_timeout", 64'(ok), 64'd1);
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int d0, input int maxc);
    bit ok;
    ok = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != d0) begin ok = 1; break; end
    end
    chk("done_within_budget", 64'(ok), 64'd1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int d0, bad;
    repeat (2) @(negedge clk);
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_avail_out", 64'(avail_out), 64'd0);
    chk("rst_done",      64'(done),      64'd0);
    chk("rst_data_out",  64'(data_out),  64'd0);
    rst = 1'b1;
    chk_en = 1;
    idle(2);

    // 1: two iterations, 60 then -8
    res_q.delete(); d0 = done_cnt;
    cfg(2, 4);
    repeat (4) beat(5, 10);
    repeat (4) beat(1, -3);
    wait_done(d0, 50);
    chk("t1_count",   64'(res_q.size()), 64'd2);
    chk("t1_res0",    qget(0), 64'd60);
    chk("t1_res1",    qget(1), 64'hFFFF_FFF8);
    chk("t1_done_lat", 64'(last_d - last_v), 64'd1);
    idle(2);

    // 2: first result held back by avail_in=0
    res_q.delete(); d0 = done_cnt;
    avail_in = 1'b0;
    cfg(2, 4);
    repeat (4) beat(5, 10);
    idle(3);
    chk("t2_avail_pending", 64'(avail_out), 64'd0);
    chk("t2_no_valid",      64'(valid_out), 64'd0);
    chk("t2_data_held",     64'(data_out),  64'd60);
    idle(2);
    avail_in = 1'b1;
    @(negedge clk);
    chk("t2_valid_on_return", 64'(valid_out), 64'd1);
    chk("t2_data_on_return",  64'(data_out),  64'd60);
    repeat (4) beat(1, -3);
    wait_done(d0, 50);
    chk("t2_count", 64'(res_q.size()), 64'd2);
    chk("t2_res0",  qget(0), 64'd60);
    chk("t2_res1",  qget(1), 64'hFFFF_FFF8);
    idle(2);

    // 3: gaps in valid_in; 3 + 7 - 2 + 50 = 58
    res_q.delete(); d0 = done_cnt;
    cfg(1, 4);
    beat(1, 2); idle(1); beat(3, 4); beat(-1, -1); idle(3); beat(100, -50);
    wait_done(d0, 50);
    chk("t3_count", 64'(res_q.size()), 64'd1);
    chk("t3_res",   qget(0), 64'd58);
    idle(2);

    // 4: reconfigure mid-run discards partial sum
    res_q.delete(); d0 = done_cnt;
    cfg(2, 4);
    beat(7, 7); beat(7, 7);
    cfg(1, 2);
    beat(1, 1); beat(1, 1);
    wait_done(d0, 50);
    chk("t4_count", 64'(res_q.size()), 64'd1);
    chk("t4_res",   qget(0), 64'd4);
    idle(2);

    // 5: asynchronous reset mid-iteration
    cfg(2, 4);
    beat(3, 3); beat(3, 3);
    #1 rst = 1'b0;
    #1;
    chk("t5_valid_out", 64'(valid_out), 64'd0);
    chk("t5_avail_out", 64'(avail_out), 64'd0);
    chk("t5_done",      64'(done),      64'd0);
    chk("t5_data_out",  64'(data_out),  64'd0);
    @(negedge clk);
    rst = 1'b1;
    res_q.delete();
    idle(10);
    chk("t5_no_result", 64'(res_q.size()), 64'd0);

    // 6: overflow in a 16-bit accumulator
    res_q.delete(); d0 = done_cnt; v16_cnt = 0;
    cfg(1, 4);
    repeat (4) beat(32'h4000, 32'h4000);
    wait_done(d0, 50);
    chk("t6_res32", qget(0), 64'h0002_0000);
    chk("t6_v16",   64'(v16_cnt), 64'd1);
`ifdef ACC_ADD_SATURATE_EN
    chk("t6_acc16", 64'(d16_data_out), 64'h7FFF);
`else
    chk("t6_acc16", 64'(d16_data_out), 64'h0000);
`endif
    idle(2);

    // 7: one read per iteration
    res_q.delete(); d0 = done_cnt;
    cfg(3, 1);
    beat(2, 3); beat(-4, 0); beat(0, 0);
    wait_done(d0, 50);
    chk("t7_count", 64'(res_q.size()), 64'd3);
    chk("t7_res0",  qget(0), 64'd5);
    chk("t7_res1",  qget(1), 64'hFFFF_FFFC);
    chk("t7_res2",  qget(2), 64'd0);
    idle(2);

    // 8: zero counts pulse done without a run
    res_q.delete(); d0 = done_cnt;
    cfg(0, 4);
    chk("t8_done_iters0", 64'(done), 64'd1);
    idle(2);
    cfg(3, 0);
    chk("t8_done_reads0", 64'(done), 64'd1);
    idle(3);
    chk("t8_no_result", 64'(res_q.size()), 64'd0);
    chk("t8_avail_low", 64'(avail_out), 64'd0);

    // 9: maximum counts, 15 iterations of 255 beats
    res_q.delete(); d0 = done_cnt;
    cfg(15, 255);
    for (int i = 0; i < 15 * 255; i++) beat(0, 1);
    wait_done(d0, 50);
    chk("t9_count", 64'(res_q.size()), 64'd15);
    bad = 0;
    foreach (res_q[i]) if (res_q[i] != 32'd255) bad++;
    chk("t9_all_255", 64'(bad), 64'd0);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time budget, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/acc_add.md
Name: acc_add

Overview:
- Per-lane accumulation stage directly downstream of the MUL module.
- Consumes GROUP_SIZE signed products per beat and reduces them into one signed accumulator.
- Emits one partial sum per iteration, after num_reads_per_iter accepted beats, repeated for num_iters iterations.
- One instance per lane; the result feeds the output write-back path.

Parameters:
GROUP_SIZE, 2, products per input beat
DATA_WIDTH, 8, operand width at MUL input; each product is 2*DATA_WIDTH bits, signed
ACC_WIDTH, 32, accumulator/output width; must be >= 2*DATA_WIDTH
LOG_MAX_ITERS, 4, width of num_iters
LOG_MAX_READS_PER_ITER, 8, width of num_reads_per_iter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
configure  in  1  one-cycle pulse; latches num_iters and num_reads_per_iter, starts a run
num_iters  in  LOG_MAX_ITERS  iterations per run
num_reads_per_iter  in  LOG_MAX_READS_PER_ITER  beats per iteration
data_in  in  2*GROUP_SIZE*DATA_WIDTH  products; product k is at bits [(k+1)*2*DATA_WIDTH-1 : k*2*DATA_WIDTH]
valid_in  in  1  data_in valid
avail_out  out  1  block accepts a beat this cycle (to MUL avail_in)
data_out  out  ACC_WIDTH  signed iteration sum
valid_out  out  1  one-cycle result strobe
avail_in  in  1  downstream can accept a result
done  out  1  one-cycle pulse after the last result of a run is issued

Behaviour:
Reset (rst=0, asynchronous):
- State IDLE; accumulator, counters and data_out = 0.
- valid_out, avail_out, done, out_pending = 0.
- Reset mid-run aborts the run; no result is emitted.

Beat acceptance:
- A beat is accepted at a rising edge where valid_in=1 and avail_out=1.
- valid_in while avail_out=0 is ignored; the producer holds it.

State machine:
- IDLE: avail_out=0.
  - configure with both counts nonzero: latch counts, clear counters and accumulator, go to ACCUM.
  - configure with either count zero: stay in IDLE and pulse done next cycle.
- ACCUM: avail_out = !out_pending (registered).
  - Each accepted beat: acc <= acc + sum of the GROUP_SIZE products, each sign-extended to ACC_WIDTH. Arithmetic is modulo 2^ACC_WIDTH.
  - On the beat where read_cnt == num_reads_per_iter-1:
    - data_out <= acc + beat sum; acc <= 0; read_cnt <= 0; iter_cnt++.
    - If avail_in=1 at that edge, valid_out=1 next cycle; otherwise out_pending=1.
  - While out_pending: at the first edge with avail_in=1, valid_out=1 for one cycle and out_pending clears. data_out is held stable meanwhile.
  - After the final iteration's result is issued (valid_out high): go to IDLE. done=1 in the cycle after that valid_out.
- configure while in ACCUM: restart immediately. Partial acc, counters and any pending result are discarded; valid_out is not raised.

Latency and throughput:
- Last beat accepted at edge t with avail_in=1 → valid_out and data_out at cycle t+1.
- Throughput is one beat per cycle.
- avail_out deasserts the cycle after an iteration's last beat is accepted if the result is pending, and reasserts the cycle after it issues.
- valid_out is never asserted for two consecutive results without an intervening avail_in=1 edge.

Boundaries:
- num_reads_per_iter=1: every beat produces a result.
- Maximum counts (15 iterations, 255 reads): counters must not wrap early.

Optional Feature:
Macro ACC_ADD_SATURATE_EN.
- Defined: each accumulate step saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. Overflow is detected from the sign of the operands and the sign of the result. Once saturated, the value stays clamped unless later addends bring it back in range (normal add from the clamped value).
- Undefined: two's-complement wrap, no clamp logic.

Test Plan:
1. Default params; configure iters=2, reads=4; 4 beats of (p1=5, p0=10), then 4 beats of (p1=1, p0=-3); avail_in=1 → two valid_out pulses, data_out=60 then 0xFFFFFFF8; done one cycle after the second pulse.
2. Same run with avail_in=0 for 5 cycles after the first result → avail_out low while pending; valid_out rises on the first cycle avail_in returns; data_out=60 stable throughout.
3. reads=4, beats issued with valid_in gaps (valid_in on cycles 0,2,3,7) → single result equal to the sum of those beats; no extra valid_out.
4. configure with iters=2, reads=4; 2 beats; second configure with iters=1, reads=2; 2 beats of (1,1) → only one result, value 4; done after it.
5. Assert rst low mid-iteration → all outputs 0 asynchronously; after release with no configure, no valid_out.
6. ACC_WIDTH=16, 4 beats of (0x4000, 0x4000): without ACC_ADD_SATURATE_EN → 0x0000; with it → 0x7FFF.
